muu_resp_arbiter: RTL and testbench
===================================

# muu_resp_arbiter

Packet-atomic round-robin arbiter that shares the single 512-bit response stream towards the network between two response sources: port 0 is the value-get responder, port 1 is the replication/bypass response path. It sits between those sources and the output packetizer. Each packet is granted whole, so beats from the two sources never interleave. The block adds one registered pipeline stage, per-port packet counters and an over-length packet detector.

## Interface
Parameters:
- META_WIDTH, 96, metadata bits prepended to each 512-bit word
- DATA_WIDTH, META_WIDTH+512, beat width on all data ports
- MAX_WORDS_IN_PACKET, 160, longest legal packet in beats

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, asynchronous, active-low
- in0_data  in  DATA_WIDTH  port 0 beat
- in0_user  in  8  port 0 user id
- in0_valid  in  1  port 0 beat valid
- in0_last  in  1  port 0 last beat of packet
- in0_ready  out  1  port 0 beat accepted when valid&ready
- in1_data / in1_user / in1_valid / in1_last / in1_ready  same as port 0, for port 1
- output_data  out  DATA_WIDTH  registered beat
- output_user  out  8  registered user id
- output_valid  out  1  beat valid
- output_last  out  1  last beat of packet
- output_ready  in  1  downstream accept
- pkt_cnt0, pkt_cnt1  out  32  packets forwarded per port, wrap modulo 2^32
- overlong_err  out  1  sticky: a packet exceeded MAX_WORDS_IN_PACKET

## Operation
State machine:
- ST_IDLE: nothing granted.
  - One request valid: grant that port.
  - Both valid: grant the port not equal to last_grant.
  - last_grant resets to 1, so port 0 wins the first tie.
- ST_GRANT0 / ST_GRANT1: forward beats from the granted port.
  - The state is left only when a beat with last=1 is accepted from the granted port. On that edge: update last_grant, increment pkt_cnt of that port, return to ST_IDLE.

Datapath:
- Output register: inN_ready = (state==ST_GRANTN) && (!output_valid || output_ready). It is combinational from state, output_valid and output_ready only, never from inN_valid.
- On input accept: output_data/user/last are loaded from the granted port and output_valid is set to 1.
- Otherwise, on output_valid&&output_ready, output_valid is cleared to 0.
- The non-granted port's ready is held at 0.

Beat counter and over-length detection:
- A 10-bit beat counter counts accepted beats of the current packet and is cleared in ST_IDLE.
- If an accepted beat is number MAX_WORDS_IN_PACKET and does not have last=1, overlong_err is set and stays set until reset.
- Forwarding continues unchanged; the arbiter never truncates or injects beats.
- The counter saturates at 1023.

## Timing
- Reset (rst_n=0, asynchronous):
  - All outputs go to 0: output_valid, output_last, in0_ready, in1_ready, pkt_cnt0, pkt_cnt1, overlong_err; output_data and output_user are also 0.
  - state=ST_IDLE, last_grant=1, beat counter=0.
- Reset asserted mid-packet discards the in-flight beat and the grant. The sources are reset by the same rst_n.
- Grant latency: inN_valid seen in ST_IDLE at edge t → state=ST_GRANTN after t → first beat accepted at t+1 → output_valid=1 after t+1. This gives 2 cycles from first valid to output.
- Throughput: 1 beat/cycle while output_ready=1.
- There is one ST_IDLE bubble cycle between consecutive packets.
- Backpressure: with output_ready=0 and output_valid=1, output_data, output_user and output_last are held stable and inN_ready=0.
- A request arriving while the other port is mid-packet waits, without bound, until that packet's last beat is accepted.
- A single-beat packet (valid&last on its first beat) is legal and completes in one accept cycle.
- pkt_cnt wraps from 0xFFFFFFFF to 0 with no flag.

## Test plan
- Single port: port 0 sends a 3-beat packet with user=5 and output_ready=1 → output beats appear at cycles 2,3,4 after the first valid; output_last only on the 3rd; output_user=5; pkt_cnt0=1.
- Tie: both ports valid in the same cycle, each with a 2-beat packet → port 0 packet is output first, then port 1 after a 1-cycle bubble; no interleaving; pkt_cnt0=pkt_cnt1=1.
- Fairness: both ports continuously send 1-beat packets for 20 packets → output alternates 0,1,0,1…; pkt_cnt0=pkt_cnt1=10.
- Backpressure: output_ready toggles 1,0,0,1 during a 4-beat port 1 packet → each beat is held stable while stalled; in1_ready=0 whenever output_valid&&!output_ready; all 4 beats are delivered in order.
- Over-length: port 0 sends 161 beats with last only on beat 161, MAX_WORDS_IN_PACKET=160 → overlong_err rises after beat 160 is accepted; all 161 beats are forwarded; pkt_cnt0=1.
- Async reset: assert rst_n=0 mid-packet (beat 2 of 4) off a clock edge → all outputs are 0 immediately; after release, a new port 1 packet is granted normally.

Source files
------------

// File: rtl/muu_resp_arbiter.sv
// Packet-atomic round-robin arbiter merging two response sources onto one
// registered output stream, with per-port packet counters and over-length detection.
module muu_resp_arbiter #(
  parameter  int unsigned META_WIDTH          = 96,
  parameter  int unsigned DATA_WIDTH          = META_WIDTH + 512,
  parameter  int unsigned MAX_WORDS_IN_PACKET = 160,
  localparam int unsigned USER_W              = 8,
  localparam int unsigned CNT_W               = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in0_data,
  input  logic [USER_W-1:0]     in0_user,
  input  logic                  in0_valid,
  input  logic                  in0_last,
  output logic                  in0_ready,
  input  logic [DATA_WIDTH-1:0] in1_data,
  input  logic [USER_W-1:0]     in1_user,
  input  logic                  in1_valid,
  input  logic                  in1_last,
  output logic                  in1_ready,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic [USER_W-1:0]     output_user,
  output logic                  output_valid,
  output logic                  output_last,
  input  logic                  output_ready,
  output logic [CNT_W-1:0]      pkt_cnt0,
  output logic [CNT_W-1:0]      pkt_cnt1,
  output logic                  overlong_err
);

  localparam int unsigned       BEAT_W        = 10;
  localparam logic [BEAT_W-1:0] BEAT_MAX      = '1;
  localparam logic [BEAT_W-1:0] BEAT_LIMIT_M1 = BEAT_W'(MAX_WORDS_IN_PACKET - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRANT0 = 2'd1,
    ST_GRANT1 = 2'd2
  } state_e;

  state_e              state_q;
  state_e              state_d;
  logic                last_grant_q;
  logic [BEAT_W-1:0]   beat_cnt_q;

  logic                out_free_c;
  logic                accept0_c;
  logic                accept1_c;
  logic                accept_c;
  logic                sel1_c;
  logic [DATA_WIDTH-1:0] sel_data_c;
  logic [USER_W-1:0]   sel_user_c;
  logic                sel_last_c;

  // Output register can take a new beat when empty or draining this cycle
  assign out_free_c = !output_valid || output_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Grant is held until the granted port's last beat is accepted
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in0_valid && in1_valid) state_d = last_grant_q ? ST_GRANT0 : ST_GRANT1;
        else if (in0_valid)         state_d = ST_GRANT0;
        else if (in1_valid)         state_d = ST_GRANT1;
      end
      ST_GRANT0: if (accept0_c && in0_last) state_d = ST_IDLE;
      ST_GRANT1: if (accept1_c && in1_last) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Ready depends only on grant and output-register occupancy, never on valid
  always_comb begin
    in0_ready = 1'b0;
    in1_ready = 1'b0;
    case (state_q)
      ST_GRANT0: in0_ready = out_free_c;
      ST_GRANT1: in1_ready = out_free_c;
      default: ;
    endcase
  end

  assign accept0_c  = in0_valid && in0_ready;
  assign accept1_c  = in1_valid && in1_ready;
  assign accept_c   = accept0_c || accept1_c;
  assign sel1_c     = (state_q == ST_GRANT1);
  assign sel_data_c = sel1_c ? in1_data : in0_data;
  assign sel_user_c = sel1_c ? in1_user : in0_user;
  assign sel_last_c = sel1_c ? in1_last : in0_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      output_data  <= '0;
      output_user  <= '0;
      output_last  <= 1'b0;
      output_valid <= 1'b0;
    end else if (accept_c) begin
      output_data  <= sel_data_c;
      output_user  <= sel_user_c;
      output_last  <= sel_last_c;
      output_valid <= 1'b1;
    end else if (output_valid && output_ready) begin
      output_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      pkt_cnt0     <= '0;
      pkt_cnt1     <= '0;
    end else begin
      if (accept_c && sel_last_c) last_grant_q <= sel1_c;
      if (accept0_c && in0_last)  pkt_cnt0     <= pkt_cnt0 + CNT_W'(1);
      if (accept1_c && in1_last)  pkt_cnt1     <= pkt_cnt1 + CNT_W'(1);
    end
  end

  // Beat counter flags a packet whose limit-th beat is not its last
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt_q   <= '0;
      overlong_err <= 1'b0;
    end else begin
      if (state_q == ST_IDLE)                        beat_cnt_q <= '0;
      else if (accept_c && (beat_cnt_q != BEAT_MAX)) beat_cnt_q <= beat_cnt_q + BEAT_W'(1);
      if (accept_c && !sel_last_c && (beat_cnt_q == BEAT_LIMIT_M1)) overlong_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_muu_resp_arbiter.sv
// Directed bench for muu_resp_arbiter: beats are captured at the output and
// compared against hand-derived order, timing and counter values.
module tb_muu_resp_arbiter;

  localparam int unsigned DW = 608;
  localparam int unsigned CW = DW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] in0_data = '0;
  logic [7:0]    in0_user = '0;
  logic          in0_valid = 1'b0;
  logic          in0_last = 1'b0;
  logic          in0_ready;
  logic [DW-1:0] in1_data = '0;
  logic [7:0]    in1_user = '0;
  logic          in1_valid = 1'b0;
  logic          in1_last = 1'b0;
  logic          in1_ready;
  logic [DW-1:0] output_data;
  logic [7:0]    output_user;
  logic          output_valid;
  logic          output_last;
  logic          output_ready = 1'b1;
  logic [31:0]   pkt_cnt0;
  logic [31:0]   pkt_cnt1;
  logic          overlong_err;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  muu_resp_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in0_data     (in0_data),
    .in0_user     (in0_user),
    .in0_valid    (in0_valid),
    .in0_last     (in0_last),
    .in0_ready    (in0_ready),
    .in1_data     (in1_data),
    .in1_user     (in1_user),
    .in1_valid    (in1_valid),
    .in1_last     (in1_last),
    .in1_ready    (in1_ready),
    .output_data  (output_data),
    .output_user  (output_user),
    .output_valid (output_valid),
    .output_last  (output_last),
    .output_ready (output_ready),
    .pkt_cnt0     (pkt_cnt0),
    .pkt_cnt1     (pkt_cnt1),
    .overlong_err (overlong_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int p, input int tag, input int i);
    logic [39:0]   k;
    logic [DW-1:0] v;
    k = {8'(p), 16'(tag), 16'(i)};
    v = DW'(k);
    v[DW-1 -: 40] = k ^ 40'hA55A5AA5A5;
    return v;
  endfunction

  // Output capture: every beat consumed downstream, plus hold checks while stalled
  logic [DW-1:0] obs_data[$];
  logic [7:0]    obs_user[$];
  bit            obs_last[$];
  bit            obs_err[$];
  int            obs_cyc[$];
  bit            stalled = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [7:0]    held_user = '0;
  logic          held_last = 1'b0;
  int            stall_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        check("hold_valid", CW'(output_valid), CW'(1));
        check("hold_data", CW'(output_data), CW'(held_data));
        check("hold_user", CW'(output_user), CW'(held_user));
        check("hold_last", CW'(output_last), CW'(held_last));
      end
      if (output_valid && !output_ready) begin
        check("ready_in_stall", CW'({in1_ready, in0_ready}), CW'(0));
        stalled   = 1'b1;
        held_data = output_data;
        held_user = output_user;
        held_last = output_last;
        stall_cnt++;
      end else begin
        stalled = 1'b0;
      end
      if (output_valid && output_ready) begin
        obs_data.push_back(output_data);
        obs_user.push_back(output_user);
        obs_last.push_back(output_last);
        obs_err.push_back(overlong_err);
        obs_cyc.push_back(cyc);
      end
    end
  end

  task automatic chk_beat(input string tag, input int idx, input logic [DW-1:0] d,
                          input logic [7:0] u, input bit l);
    if (idx < obs_data.size()) begin
      check({tag, "_data"}, CW'(obs_data[idx]), CW'(d));
      check({tag, "_user"}, CW'(obs_user[idx]), CW'(u));
      check({tag, "_last"}, CW'(obs_last[idx]), CW'(l));
    end else begin
      check({tag, "_missing"}, CW'(obs_data.size()), CW'(idx + 1));
    end
  endtask

  task automatic send0(input int n, input logic [7:0] user, input int tag);
    for (int i = 0; i < n; i++) begin
      int waited;
      bit done;
      waited = 0;
      done = 1'b0;
      in0_valid = 1'b1;
      in0_data  = mk(0, tag, i);
      in0_user  = user;
      in0_last  = (i == n - 1);
      while (!done) begin
        @(negedge clk);
        if (in0_ready) begin
          @(posedge clk); #1;
          done = 1'b1;
        end else begin
          waited++;
          if (waited > 200) begin
            check("timeout0", CW'(waited), CW'(0));
            done = 1'b1;
          end
        end
      end
    end
    in0_valid = 1'b0;
    in0_last  = 1'b0;
  endtask

  task automatic send1(input int n, input logic [7:0] user, input int tag);
    for (int i = 0; i < n; i++) begin
      int waited;
      bit done;
      waited = 0;
      done = 1'b0;
      in1_valid = 1'b1;
      in1_data  = mk(1, tag, i);
      in1_user  = user;
      in1_last  = (i == n - 1);
      while (!done) begin
        @(negedge clk);
        if (in1_ready) begin
          @(posedge clk); #1;
          done = 1'b1;
        end else begin
          waited++;
          if (waited > 200) begin
            check("timeout1", CW'(waited), CW'(0));
            done = 1'b1;
          end
        end
      end
    end
    in1_valid = 1'b0;
    in1_last  = 1'b0;
  endtask

  task automatic do_reset();
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    in0_last  = 1'b0;
    in1_last  = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int b;
    int c0;
    logic [3:0] pat;

    // Reset values
    rst_n = 1'b0;
    #7;
    check("rst_valid", CW'(output_valid), CW'(0));
    check("rst_last", CW'(output_last), CW'(0));
    check("rst_data", CW'(output_data), CW'(0));
    check("rst_user", CW'(output_user), CW'(0));
    check("rst_ready", CW'({in1_ready, in0_ready}), CW'(0));
    check("rst_cnt0", CW'(pkt_cnt0), CW'(0));
    check("rst_cnt1", CW'(pkt_cnt1), CW'(0));
    check("rst_err", CW'(overlong_err), CW'(0));
    do_reset();

    // Single port, 3 beats: output at cycles 2,3,4 after first valid
    b = obs_data.size();
    c0 = cyc;
    send0(3, 8'd5, 1);
    repeat (3) @(posedge clk); #1;
    check("t1_count", CW'(obs_data.size() - b), CW'(3));
    for (int i = 0; i < 3; i++) begin
      chk_beat("t1", b + i, mk(0, 1, i), 8'd5, (i == 2));
      if (b + i < obs_cyc.size()) check("t1_latency", CW'(obs_cyc[b + i] - c0), CW'(2 + i));
    end
    check("t1_cnt0", CW'(pkt_cnt0), CW'(1));
    check("t1_cnt1", CW'(pkt_cnt1), CW'(0));

    // Tie: port 0 first, one bubble, then port 1
    do_reset();
    b = obs_data.size();
    fork
      send0(2, 8'h10, 2);
      send1(2, 8'h21, 2);
    join
    repeat (3) @(posedge clk); #1;
    check("t2_count", CW'(obs_data.size() - b), CW'(4));
    chk_beat("t2_b0", b + 0, mk(0, 2, 0), 8'h10, 1'b0);
    chk_beat("t2_b1", b + 1, mk(0, 2, 1), 8'h10, 1'b1);
    chk_beat("t2_b2", b + 2, mk(1, 2, 0), 8'h21, 1'b0);
    chk_beat("t2_b3", b + 3, mk(1, 2, 1), 8'h21, 1'b1);
    if (b + 2 < obs_cyc.size()) check("t2_bubble", CW'(obs_cyc[b + 2] - obs_cyc[b + 1]), CW'(2));
    check("t2_cnt0", CW'(pkt_cnt0), CW'(1));
    check("t2_cnt1", CW'(pkt_cnt1), CW'(1));

    // Fairness: continuous single-beat packets alternate 0,1,0,1...
    do_reset();
    b = obs_data.size();
    fork
      begin for (int k = 0; k < 10; k++) send0(1, 8'h10, 100 + k); end
      begin for (int k = 0; k < 10; k++) send1(1, 8'h21, 200 + k); end
    join
    repeat (3) @(posedge clk); #1;
    check("t3_count", CW'(obs_data.size() - b), CW'(20));
    for (int i = 0; i < 20; i++)
      chk_beat("t3", b + i, mk(i % 2, 100 + 100 * (i % 2) + i / 2, 0),
               (i % 2 == 0) ? 8'h10 : 8'h21, 1'b1);
    check("t3_cnt0", CW'(pkt_cnt0), CW'(10));
    check("t3_cnt1", CW'(pkt_cnt1), CW'(10));

    // Backpressure: output_ready 1,0,0,1 during a 4-beat port 1 packet
    do_reset();
    b = obs_data.size();
    c0 = stall_cnt;
    pat = 4'b1001;
    fork
      send1(4, 8'h33, 4);
      begin
        for (int k = 0; k < 24; k++) begin
          output_ready = pat[k % 4];
          @(posedge clk); #1;
        end
        output_ready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    check("t4_count", CW'(obs_data.size() - b), CW'(4));
    for (int i = 0; i < 4; i++) chk_beat("t4", b + i, mk(1, 4, i), 8'h33, (i == 3));
    check("t4_stalls_seen", CW'(stall_cnt > c0), CW'(1));
    check("t4_cnt1", CW'(pkt_cnt1), CW'(1));
    check("t4_cnt0", CW'(pkt_cnt0), CW'(0));

    // Over-length: exactly 160 beats is legal, 161 sets the sticky flag
    do_reset();
    send0(160, 8'h44, 5);
    repeat (3) @(posedge clk); #1;
    check("t5_exact_limit_err", CW'(overlong_err), CW'(0));
    b = obs_data.size();
    send0(161, 8'h45, 6);
    repeat (3) @(posedge clk); #1;
    check("t5_count", CW'(obs_data.size() - b), CW'(161));
    for (int i = 0; i < 161; i++)
      if (b + i < obs_data.size()) check("t5_data", CW'(obs_data[b + i]), CW'(mk(0, 6, i)));
    if (b + 160 < obs_data.size()) begin
      check("t5_err_beat159", CW'(obs_err[b + 158]), CW'(0));
      check("t5_err_beat160", CW'(obs_err[b + 159]), CW'(1));
      check("t5_last_beat160", CW'(obs_last[b + 159]), CW'(0));
      check("t5_last_beat161", CW'(obs_last[b + 160]), CW'(1));
    end
    check("t5_cnt0", CW'(pkt_cnt0), CW'(2));
    send0(2, 8'h46, 7);
    repeat (3) @(posedge clk); #1;
    check("t5_err_sticky", CW'(overlong_err), CW'(1));

    // Async reset mid-packet (beat 2 of 4), then a fresh port 1 packet
    do_reset();
    in0_valid = 1'b1;
    in0_user  = 8'd3;
    in0_last  = 1'b0;
    in0_data  = mk(0, 8, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    in0_data = mk(0, 8, 1);
    @(posedge clk); #1;
    in0_data = mk(0, 8, 2);
    check("t6_pre_valid", CW'(output_valid), CW'(1));
    check("t6_pre_data", CW'(output_data), CW'(mk(0, 8, 1)));
    #2;
    rst_n     = 1'b0;
    in0_valid = 1'b0;
    #1;
    check("t6_valid", CW'(output_valid), CW'(0));
    check("t6_last", CW'(output_last), CW'(0));
    check("t6_data", CW'(output_data), CW'(0));
    check("t6_user", CW'(output_user), CW'(0));
    check("t6_ready", CW'({in1_ready, in0_ready}), CW'(0));
    check("t6_cnt0", CW'(pkt_cnt0), CW'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    b = obs_data.size();
    send1(2, 8'h55, 9);
    repeat (3) @(posedge clk); #1;
    check("t6_count", CW'(obs_data.size() - b), CW'(2));
    for (int i = 0; i < 2; i++) chk_beat("t6", b + i, mk(1, 9, i), 8'h55, (i == 1));
    check("t6_cnt1", CW'(pkt_cnt1), CW'(1));
    check("t6_cnt0_after", CW'(pkt_cnt0), CW'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
